// File: rtl/rename_stage_nw.sv
// N-wide register-rename stage: speculative RAT, committed RAT and circular free list.
// Renames up to WIDTH instructions per cycle with intra-group RAW/WAW bypass; flush restores committed state.
module rename_stage_nw #(
    parameter int WIDTH    = 2,
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHY  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_lane_vld,
    input  logic [WIDTH-1:0]            in_wr_reg,
    input  logic [WIDTH*$clog2(NUM_ARCH)-1:0] in_rs1,
    input  logic [WIDTH*$clog2(NUM_ARCH)-1:0] in_rs2,
    input  logic [WIDTH*$clog2(NUM_ARCH)-1:0] in_rd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_lane_vld,
    output logic [WIDTH*$clog2(NUM_PHY)-1:0]  out_prs1,
    output logic [WIDTH*$clog2(NUM_PHY)-1:0]  out_prs2,
    output logic [WIDTH*$clog2(NUM_PHY)-1:0]  out_prd,
    output logic [WIDTH*$clog2(NUM_PHY)-1:0]  out_old_prd,
    input  logic [WIDTH-1:0]            cm_vld,
    input  logic [WIDTH*$clog2(NUM_ARCH)-1:0] cm_rd,
    input  logic [WIDTH*$clog2(NUM_PHY)-1:0]  cm_prd,
    input  logic [WIDTH*$clog2(NUM_PHY)-1:0]  cm_old_prd,
    input  logic                        flush,
    output logic [$clog2(NUM_PHY):0]    free_count
);

    localparam int AS = $clog2(NUM_ARCH);
    localparam int PS = $clog2(NUM_PHY);
    localparam int PW = PS + 1;

    logic [PS-1:0] spec_rat_q  [NUM_ARCH];
    logic [PS-1:0] spec_rat_d  [NUM_ARCH];
    logic [PS-1:0] com_rat_q   [NUM_ARCH];
    logic [PS-1:0] com_rat_d   [NUM_ARCH];
    logic [PS-1:0] free_list_q [NUM_PHY];
    logic [PS-1:0] free_list_d [NUM_PHY];

    // Wrap-bit pointers: tail - head is the occupancy, full and empty never alias.
    logic [PW-1:0] alloc_hd_q, alloc_hd_d;
    logic [PW-1:0] com_hd_q, com_hd_d;
    logic [PW-1:0] tail_q, tail_d;

    logic                       out_valid_q, out_valid_d;
    logic [WIDTH-1:0]           out_lane_vld_q;
    logic [WIDTH-1:0][PS-1:0]   out_prs1_q, out_prs2_q, out_prd_q, out_old_prd_q;

    logic [WIDTH-1:0]           wlane;
    logic [PW-1:0]              need;
    logic [WIDTH-1:0][PS-1:0]   ren_prs1, ren_prs2, ren_prd, ren_old;
    logic [PW-1:0]              cm_cnt;
    logic                       accept;

    assign free_count = tail_q - alloc_hd_q;
    assign in_ready   = !reset && !flush && (!out_valid_q || out_ready) && (free_count >= need);
    assign accept     = in_valid && in_ready;

    always_comb begin : rename_c
        logic [PW-1:0] slot;
        logic [AS-1:0] rd_j, rs1_j, rs2_j, rd_k;
        need     = '0;
        wlane    = '0;
        ren_prs1 = '0;
        ren_prs2 = '0;
        ren_prd  = '0;
        ren_old  = '0;
        slot     = '0;
        rd_k     = '0;
        for (int j = 0; j < WIDTH; j++) begin
            rd_j  = in_rd[j*AS +: AS];
            rs1_j = in_rs1[j*AS +: AS];
            rs2_j = in_rs2[j*AS +: AS];
            wlane[j]    = in_lane_vld[j] && in_wr_reg[j] && (rd_j != '0);
            slot        = alloc_hd_q + need;
            ren_prs1[j] = (rs1_j == '0) ? '0 : spec_rat_q[rs1_j];
            ren_prs2[j] = (rs2_j == '0) ? '0 : spec_rat_q[rs2_j];
            ren_old[j]  = spec_rat_q[rd_j];
            // Ascending scan so the youngest older writer wins; x0 never matches a writer.
            for (int k = 0; k < j; k++) begin
                rd_k = in_rd[k*AS +: AS];
                if (wlane[k] && (rd_k == rs1_j)) ren_prs1[j] = ren_prd[k];
                if (wlane[k] && (rd_k == rs2_j)) ren_prs2[j] = ren_prd[k];
                if (wlane[k] && (rd_k == rd_j))  ren_old[j]  = ren_prd[k];
            end
            if (wlane[j]) begin
                ren_prd[j] = free_list_q[slot[PS-1:0]];
                need       = need + PW'(1);
            end else begin
                ren_old[j] = '0;
            end
        end
    end

    always_comb begin : commit_c
        logic [PW-1:0] wslot;
        com_rat_d   = com_rat_q;
        free_list_d = free_list_q;
        cm_cnt      = '0;
        wslot       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cm_vld[i]) begin
                wslot = tail_q + cm_cnt;
                com_rat_d[cm_rd[i*AS +: AS]] = cm_prd[i*PS +: PS];
                free_list_d[wslot[PS-1:0]]   = cm_old_prd[i*PS +: PS];
                cm_cnt = cm_cnt + PW'(1);
            end
        end
        tail_d   = tail_q + cm_cnt;
        com_hd_d = com_hd_q + cm_cnt;
    end

    always_comb begin : spec_c
        spec_rat_d = spec_rat_q;
        alloc_hd_d = alloc_hd_q;
        if (flush) begin
            spec_rat_d = com_rat_d;
            alloc_hd_d = com_hd_d;
        end else if (accept) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (wlane[j]) spec_rat_d[in_rd[j*AS +: AS]] = ren_prd[j];
            end
            alloc_hd_d = alloc_hd_q + need;
        end
    end

    always_comb begin : outv_c
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (accept)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                spec_rat_q[i] <= PS'(i);
                com_rat_q[i]  <= PS'(i);
            end
            for (int i = 0; i < NUM_PHY; i++) begin
                free_list_q[i] <= (i < NUM_PHY - NUM_ARCH) ? PS'(i + NUM_ARCH) : '0;
            end
            alloc_hd_q     <= '0;
            com_hd_q       <= '0;
            tail_q         <= PW'(NUM_PHY - NUM_ARCH);
            out_valid_q    <= 1'b0;
            out_lane_vld_q <= '0;
            out_prs1_q     <= '0;
            out_prs2_q     <= '0;
            out_prd_q      <= '0;
            out_old_prd_q  <= '0;
        end else begin
            spec_rat_q  <= spec_rat_d;
            com_rat_q   <= com_rat_d;
            free_list_q <= free_list_d;
            alloc_hd_q  <= alloc_hd_d;
            com_hd_q    <= com_hd_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_lane_vld_q <= in_lane_vld;
                out_prs1_q     <= ren_prs1;
                out_prs2_q     <= ren_prs2;
                out_prd_q      <= ren_prd;
                out_old_prd_q  <= ren_old;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_lane_vld = out_lane_vld_q;
    assign out_prs1     = out_prs1_q;
    assign out_prs2     = out_prs2_q;
    assign out_prd      = out_prd_q;
    assign out_old_prd  = out_old_prd_q;

endmodule

// File: tb/tb_rename_stage_nw.sv
// Directed bench for rename_stage_nw (WIDTH=2, 32 arch, 64 phys) with hand-computed expectations.
module tb_rename_stage_nw;

    localparam int W  = 2;
    localparam int AS = 5;
    localparam int PS = 6;

    logic              clk, reset;
    logic              in_valid, in_ready;
    logic [W-1:0]      in_lane_vld, in_wr_reg;
    logic [W*AS-1:0]   in_rs1, in_rs2, in_rd;
    logic              out_valid, out_ready;
    logic [W-1:0]      out_lane_vld;
    logic [W*PS-1:0]   out_prs1, out_prs2, out_prd, out_old_prd;
    logic [W-1:0]      cm_vld;
    logic [W*AS-1:0]   cm_rd;
    logic [W*PS-1:0]   cm_prd, cm_old_prd;
    logic              flush;
    logic [PS:0]       free_count;

    int tests = 0;
    int fails = 0;

    rename_stage_nw #(.WIDTH(W), .NUM_ARCH(32), .NUM_PHY(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_vld(in_lane_vld), .in_wr_reg(in_wr_reg),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd), .out_old_prd(out_old_prd),
        .cm_vld(cm_vld), .cm_rd(cm_rd), .cm_prd(cm_prd), .cm_old_prd(cm_old_prd),
        .flush(flush), .free_count(free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_lane_vld = '0;
        in_wr_reg   = '0;
        in_rs1      = '0;
        in_rs2      = '0;
        in_rd       = '0;
    endtask

    task automatic set_lane(input int l, input logic vld, input logic wr,
                            input int rs1, input int rs2, input int rd);
        in_lane_vld[l]      = vld;
        in_wr_reg[l]        = wr;
        in_rs1[l*AS +: AS]  = AS'(rs1);
        in_rs2[l*AS +: AS]  = AS'(rs2);
        in_rd[l*AS +: AS]   = AS'(rd);
    endtask

    task automatic chk_lane(input string tag, input int l, input int prs1, input int prs2,
                            input int prd, input int old);
        chk({tag, ".prs1"}, 32'(out_prs1[l*PS +: PS]), prs1);
        chk({tag, ".prs2"}, 32'(out_prs2[l*PS +: PS]), prs2);
        chk({tag, ".prd"},  32'(out_prd[l*PS +: PS]), prd);
        chk({tag, ".old"},  32'(out_old_prd[l*PS +: PS]), old);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        cm_vld = '0; cm_rd = '0; cm_prd = '0; cm_old_prd = '0;
        clr_in();
        step();
        in_valid = 1'b1;
        set_lane(0, 1, 1, 2, 3, 1);
        #1;
        chk("rst.in_ready", 32'(in_ready), 0);
        step();
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_prd", 32'(out_prd), 0);
        chk("rst.free_count", 32'(free_count), 32);
        reset = 1'b0;

        // add x1<-x2,x3 ; add x4<-x1,x1
        clr_in();
        set_lane(0, 1, 1, 2, 3, 1);
        set_lane(1, 1, 1, 1, 1, 4);
        #1;
        chk("g1.in_ready", 32'(in_ready), 1);
        step();
        chk("g1.out_valid", 32'(out_valid), 1);
        chk_lane("g1.l0", 0, 2, 3, 32, 1);
        chk_lane("g1.l1", 1, 32, 32, 33, 4);
        chk("g1.free_count", 32'(free_count), 30);

        // x5 written twice in one group
        clr_in();
        set_lane(0, 1, 1, 0, 0, 5);
        set_lane(1, 1, 1, 5, 0, 5);
        step();
        chk_lane("waw.l0", 0, 0, 0, 34, 5);
        chk_lane("waw.l1", 1, 34, 0, 35, 34);

        // reader of x5 sees the younger writer; lane 1 invalid
        clr_in();
        set_lane(0, 1, 1, 5, 1, 6);
        set_lane(1, 0, 1, 2, 2, 7);
        step();
        chk_lane("rd5.l0", 0, 35, 32, 36, 6);
        chk("rd5.l1.prd", 32'(out_prd[PS +: PS]), 0);
        chk("rd5.lane_vld", 32'(out_lane_vld), 1);
        chk("rd5.free_count", 32'(free_count), 27);

        // downstream stall for 5 cycles
        out_ready = 1'b0;
        clr_in();
        set_lane(0, 1, 1, 3, 3, 0);
        set_lane(1, 0, 1, 3, 3, 7);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall.in_ready", 32'(in_ready), 0);
            step();
            chk("stall.out_valid", 32'(out_valid), 1);
            chk("stall.prd0", 32'(out_prd[0 +: PS]), 36);
            chk("stall.prs1_0", 32'(out_prs1[0 +: PS]), 35);
            chk("stall.free_count", 32'(free_count), 27);
        end

        // release: group writing x0 / invalid lane allocates nothing
        out_ready = 1'b1;
        #1;
        chk("x0.in_ready", 32'(in_ready), 1);
        step();
        chk("x0.out_valid", 32'(out_valid), 1);
        chk("x0.prd", 32'(out_prd), 0);
        chk("x0.old", 32'(out_old_prd), 0);
        chk("x0.free_count", 32'(free_count), 27);

        // commit first group and flush in the same cycle
        clr_in();
        set_lane(0, 1, 1, 1, 1, 9);
        flush = 1'b1;
        cm_vld = 2'b11;
        cm_rd  = {AS'(4), AS'(1)};
        cm_prd = {PS'(33), PS'(32)};
        cm_old_prd = {PS'(4), PS'(1)};
        #1;
        chk("flush.in_ready", 32'(in_ready), 0);
        step();
        flush = 1'b0;
        cm_vld = '0;
        chk("flush.out_valid", 32'(out_valid), 0);
        chk("flush.free_count", 32'(free_count), 32);

        // spec_rat now equals committed RAT; freed slots reissued in order
        clr_in();
        set_lane(0, 1, 1, 1, 4, 8);
        set_lane(1, 1, 1, 5, 6, 9);
        #1;
        chk("post.in_ready", 32'(in_ready), 1);
        step();
        chk_lane("post.l0", 0, 32, 33, 34, 8);
        chk_lane("post.l1", 1, 5, 6, 35, 9);
        chk("post.free_count", 32'(free_count), 30);

        // drain the free list: 15 groups of two writers
        clr_in();
        set_lane(0, 1, 1, 1, 2, 10);
        set_lane(1, 1, 1, 3, 4, 11);
        for (int g = 0; g < 15; g++) begin
            #1;
            chk("drain.in_ready", 32'(in_ready), 1);
            step();
            if (g == 0) begin
                chk("drain.first.prd0", 32'(out_prd[0 +: PS]), 36);
                chk("drain.first.prd1", 32'(out_prd[PS +: PS]), 37);
            end
        end
        chk("drain.last.prd0", 32'(out_prd[0 +: PS]), 1);
        chk("drain.last.prd1", 32'(out_prd[PS +: PS]), 4);
        chk("drain.free_count", 32'(free_count), 0);

        // empty free list: writer blocked, non-writer still accepted
        clr_in();
        set_lane(0, 1, 0, 1, 1, 12);
        #1;
        chk("empty.nowrite.in_ready", 32'(in_ready), 1);
        clr_in();
        set_lane(0, 1, 1, 1, 1, 12);
        #1;
        chk("empty.in_ready", 32'(in_ready), 0);
        cm_vld = 2'b01;
        cm_rd  = {AS'(0), AS'(7)};
        cm_prd = {PS'(0), PS'(40)};
        cm_old_prd = {PS'(0), PS'(7)};
        #1;
        chk("empty.commit.in_ready", 32'(in_ready), 0);
        step();
        cm_vld = '0;
        chk("reuse.free_count", 32'(free_count), 1);
        chk("reuse.in_ready", 32'(in_ready), 1);
        step();
        chk("reuse.prd0", 32'(out_prd[0 +: PS]), 7);
        chk("reuse.old0", 32'(out_old_prd[0 +: PS]), 12);
        chk("reuse.free_count", 32'(free_count), 0);

        in_valid = 1'b0;
        clr_in();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
